shift_collector: RTL and testbench
==================================

SHIFT_COLLECTOR -- requirements
Module: shift_collector

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the bit width of one element.
REQ-002 The module SHALL have parameter BUFFER_SIZE, default 16, giving the elements per parallel word; legal range is 1 or greater.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port data_in, input, WIDTH bits: one serial element.
REQ-006 The module SHALL have port data_in_valid, input, 1 bit: data_in holds a valid element.
REQ-007 The module SHALL have port data_in_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-008 The module SHALL have port data_out, output, unpacked array [BUFFER_SIZE-1:0] of WIDTH bits: the assembled parallel word.
REQ-009 The module SHALL have port data_out_valid, output, 1 bit: data_out holds a complete word.
REQ-010 The module SHALL have port data_out_ready, input, 1 bit: the downstream consumer takes data_out this cycle.

Function
REQ-011 An input transfer SHALL occur on a rising edge where data_in_valid && data_in_ready; an output transfer SHALL occur where data_out_valid && data_out_ready.
REQ-012 Internal state SHALL be: a register bank of BUFFER_SIZE x WIDTH; an index counter of max(1,$clog2(BUFFER_SIZE)+1) bits; and an FSM with states COLLECT and FULL.
REQ-013 In COLLECT, an input transfer SHALL write data_in to bank[count] and increment count; the first accepted element lands in index 0.
REQ-014 In COLLECT, the input transfer that writes index BUFFER_SIZE-1 SHALL move the FSM to FULL and clear count to 0.
REQ-015 data_out_valid SHALL be registered and high exactly while the FSM is in FULL; latency from the last input transfer to data_out_valid high is 1 cycle.
REQ-016 data_out[i] SHALL drive bank[i] combinationally for all i.
REQ-017 data_in_ready SHALL be combinational: !rst && (state==COLLECT || data_out_ready).
REQ-018 In FULL without an output transfer, the bank, count and state SHALL hold, so data_out stays stable while data_out_valid && !data_out_ready.
REQ-019 In FULL with an output transfer and no input transfer, the FSM SHALL return to COLLECT with count 0.
REQ-020 In FULL with simultaneous output and input transfers, the block SHALL write data_in to bank[0] and set count to 1. When BUFFER_SIZE>1 it SHALL enter COLLECT; when BUFFER_SIZE==1 it SHALL stay in FULL. This gives back-to-back words with no bubble.
REQ-021 Bank entries not yet overwritten in the current word SHALL retain old contents; they are not cleared between words.
REQ-022 Sustained throughput SHALL be one element per cycle when data_in_valid and data_out_ready are held high.
REQ-023 data_in_valid while data_in_ready is low SHALL have no effect; the block never drops or duplicates an accepted element.
REQ-024 A word SHALL be emitted only when BUFFER_SIZE elements have been collected; there is no partial-word flush.

Reset
REQ-025 While rst is high at a rising edge, the block SHALL set: FSM to COLLECT, count to 0, every bank entry to 0, data_out_valid to 0.
REQ-026 data_in_ready SHALL be 0 during any cycle rst is high, and SHALL be 1 in the first cycle after rst deasserts.
REQ-027 Reset SHALL take priority over any simultaneous transfer.
REQ-028 Reset mid-word or in FULL SHALL discard all collected elements; the first element accepted after reset lands in index 0.

Verification (WIDTH=8, BUFFER_SIZE=4 unless stated)
REQ-029 The bench SHALL cover basic fill: after reset, send 0x11,0x22,0x33,0x44 on consecutive cycles with data_out_ready=1. Required: data_out_valid rises the cycle after 0x44 is accepted, and data_out = {[0]=0x11,[1]=0x22,[2]=0x33,[3]=0x44}.
REQ-030 The bench SHALL cover backpressure: fill with 0xA0..0xA3 while data_out_ready=0 for 5 cycles. Required: data_in_ready=0 and data_out stable during those 5 cycles; one output transfer occurs when ready rises.
REQ-031 The bench SHALL cover streaming: send 0x00..0x0B continuously with data_in_valid=1 and data_out_ready=1. Required: three words {00..03},{04..07},{08..0B}; data_in_ready stays 1 throughout; no gaps between words.
REQ-032 The bench SHALL cover input gaps: send 4 elements with random data_in_valid idle cycles between them. Required: the word has correct order, and data_out_valid asserts only after the 4th accepted element.
REQ-033 The bench SHALL cover reset mid-word: accept 0x55,0x66, assert rst for 1 cycle, then send 0x01..0x04. Required: output word {01,02,03,04}; data_out_valid stays 0 until then.
REQ-034 The bench SHALL cover BUFFER_SIZE=1: stream 0x7E,0x7F with data_out_ready=1. Required: data_out_valid stays high for 2 consecutive cycles with data_out[0]=0x7E then 0x7F.

Source files
------------

// File: rtl/shift_collector.sv
// Purpose: collects BUFFER_SIZE serial elements into one parallel word (index 0 first).
// Latency: data_out_valid rises 1 cycle after the last element of a word is accepted.
// Backpressure: input stalls while a full word waits; a taken word plus a new element share a cycle.
module shift_collector #(
    parameter int WIDTH       = 8,
    parameter int BUFFER_SIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic [WIDTH-1:0] data_out [BUFFER_SIZE-1:0],
    output logic             data_out_valid,
    input  logic             data_out_ready
);

    localparam int CW = ($clog2(BUFFER_SIZE) + 1 > 1) ? $clog2(BUFFER_SIZE) + 1 : 1;
    localparam logic [CW-1:0] LAST = CW'(BUFFER_SIZE - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] bank [BUFFER_SIZE-1:0];
    logic             wr_en;
    logic [CW-1:0]    wr_idx;
    logic             in_xfer, out_xfer;

    assign data_in_ready = !rst && (state == COLLECT || data_out_ready);
    assign in_xfer       = data_in_valid && data_in_ready;
    assign out_xfer      = data_out_valid && data_out_ready;
    assign data_out      = bank;

    always_comb begin
        state_n = state;
        count_n = count;
        wr_en   = 1'b0;
        wr_idx  = count;
        case (state)
            COLLECT: begin
                if (in_xfer) begin
                    wr_en = 1'b1;
                    if (count == LAST) begin
                        state_n = FULL;
                        count_n = '0;
                    end else begin
                        count_n = count + CW'(1);
                    end
                end
            end
            FULL: begin
                if (out_xfer) begin
                    if (in_xfer) begin
                        // The new element starts the next word while the current one leaves.
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        count_n = CW'(1);
                        state_n = (BUFFER_SIZE > 1) ? COLLECT : FULL;
                    end else begin
                        state_n = COLLECT;
                        count_n = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= COLLECT;
            count          <= '0;
            data_out_valid <= 1'b0;
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                bank[i] <= '0;
            end
        end else begin
            state          <= state_n;
            count          <= count_n;
            data_out_valid <= (state_n == FULL);
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                if (wr_en && wr_idx == CW'(i)) begin
                    bank[i] <= data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_collector.sv
// Bench for shift_collector: BUFFER_SIZE=4 instance against a stream-position model, plus a BUFFER_SIZE=1 instance.
module tb_shift_collector;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // BUFFER_SIZE = 4 instance
    logic       rst, div, dir, dov, dor;
    logic [7:0] din;
    logic [7:0] dout [3:0];

    shift_collector #(.WIDTH(8), .BUFFER_SIZE(4)) dut4 (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(div), .data_in_ready(dir),
        .data_out(dout), .data_out_valid(dov), .data_out_ready(dor)
    );

    // BUFFER_SIZE = 1 instance
    logic       s_rst, s_div, s_dir, s_dov, s_dor;
    logic [7:0] s_din;
    logic [7:0] s_dout [0:0];

    shift_collector #(.WIDTH(8), .BUFFER_SIZE(1)) dut1 (
        .clk(clk), .rst(s_rst), .data_in(s_din), .data_in_valid(s_div), .data_in_ready(s_dir),
        .data_out(s_dout), .data_out_valid(s_dov), .data_out_ready(s_dor)
    );

    int tests = 0;
    int fails = 0;
    int dut_words = 0;

    // Reference model: every element accepted since reset, in order, and words taken so far.
    logic [7:0] acc [$];
    int         words_out = 0;

    function automatic logic exp_valid();
        return (acc.size() - words_out * 4) >= 4;
    endfunction

    // Slot i holds the most recent accepted element whose stream position is i mod 4.
    function automatic logic [7:0] exp_slot(int i);
        int n = acc.size();
        if (n > i) return acc[((n - 1 - i) / 4) * 4 + i];
        return 8'h00;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word4();
        return {dout[3], dout[2], dout[1], dout[0]};
    endfunction

    // One cycle: check outputs against the model, clock, then apply the transfers to the model.
    task automatic tick();
        logic ev, er, in_x, out_x;
        #1;
        ev = exp_valid();
        er = !rst && (!ev || dor);
        chk("valid", {31'd0, dov}, {31'd0, ev});
        chk("ready", {31'd0, dir}, {31'd0, er});
        for (int i = 0; i < 4; i++) chk($sformatf("data_out[%0d]", i), {24'd0, dout[i]}, {24'd0, exp_slot(i)});
        if (dov === 1'b1 && dor === 1'b1 && rst === 1'b0) dut_words++;
        in_x  = div && er;
        out_x = ev && dor;
        @(posedge clk);
        #1;
        if (rst) begin
            acc.delete();
            words_out = 0;
        end else begin
            if (out_x) words_out++;
            if (in_x) acc.push_back(din);
        end
    endtask

    initial begin
        int w0;
        logic [31:0] held;

        rst = 1'b1; div = 1'b0; dor = 1'b0; din = 8'h00;
        s_rst = 1'b1; s_div = 1'b0; s_dor = 1'b0; s_din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and first cycle after reset
        #1;
        chk("reset_valid", {31'd0, dov}, 32'd0);
        chk("reset_ready", {31'd0, dir}, 32'd1);
        chk("reset_word", word4(), 32'h0);
        tick();

        // Basic fill
        dor = 1'b1;
        din = 8'h11; div = 1'b1; tick();
        din = 8'h22; tick();
        din = 8'h33; tick();
        din = 8'h44; tick();
        div = 1'b0;
        chk("fill_valid", {31'd0, dov}, 32'd1);
        chk("fill_word", word4(), 32'h44332211);
        tick();

        // Backpressure: full word held for 5 cycles with the input also offered
        dor = 1'b0; div = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'hA0 + 8'(i);
            tick();
        end
        held = 32'hA3A2A1A0;
        for (int i = 0; i < 5; i++) begin
            din = 8'($urandom);
            #1;
            chk("bp_ready", {31'd0, dir}, 32'd0);
            chk("bp_word", word4(), held);
            tick();
        end
        div = 1'b0; dor = 1'b1;
        w0 = dut_words;
        tick();
        chk("bp_one_xfer", dut_words - w0, 32'd1);
        chk("bp_valid_drop", {31'd0, dov}, 32'd0);

        // Streaming 0x00..0x0B with no bubbles
        w0 = dut_words;
        div = 1'b1; dor = 1'b1;
        for (int i = 0; i < 12; i++) begin
            din = 8'(i);
            #1;
            chk("stream_ready", {31'd0, dir}, 32'd1);
            tick();
        end
        chk("stream_last_word", word4(), 32'h0B0A0908);
        div = 1'b0;
        tick();
        chk("stream_words", dut_words - w0, 32'd3);

        // Input gaps
        for (int e = 0; e < 4; e++) begin
            div = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            din = 8'($urandom);
            div = 1'b1;
            tick();
        end
        div = 1'b0;
        tick();

        // Reset mid-word
        div = 1'b1;
        din = 8'h55; tick();
        din = 8'h66; tick();
        div = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        div = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = 8'(i);
            #1;
            chk("rst_mid_valid_low", {31'd0, dov}, 32'd0);
            tick();
        end
        div = 1'b0;
        chk("rst_mid_word", word4(), 32'h04030201);
        chk("rst_mid_valid", {31'd0, dov}, 32'd1);
        tick();

        // Randomised traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            div = 1'($urandom);
            dor = ($urandom_range(0, 3) != 0);
            din = 8'($urandom);
            tick();
        end
        rst = 1'b0; div = 1'b0; dor = 1'b1;
        tick();

        // BUFFER_SIZE = 1: back-to-back single-element words
        @(posedge clk);
        #1;
        s_rst = 1'b0; s_dor = 1'b1; s_div = 1'b1; s_din = 8'h7E;
        #1;
        chk("bs1_ready0", {31'd0, s_dir}, 32'd1);
        chk("bs1_valid0", {31'd0, s_dov}, 32'd0);
        @(posedge clk);
        #1;
        s_din = 8'h7F;
        #1;
        chk("bs1_valid1", {31'd0, s_dov}, 32'd1);
        chk("bs1_data1", {24'd0, s_dout[0]}, 32'h7E);
        chk("bs1_ready1", {31'd0, s_dir}, 32'd1);
        @(posedge clk);
        #1;
        s_div = 1'b0;
        #1;
        chk("bs1_valid2", {31'd0, s_dov}, 32'd1);
        chk("bs1_data2", {24'd0, s_dout[0]}, 32'h7F);
        @(posedge clk);
        #2;
        chk("bs1_valid3", {31'd0, s_dov}, 32'd0);
        chk("bs1_data3", {24'd0, s_dout[0]}, 32'h7F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
